// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered MIPS-I decode stage between fetch and execute.
// Splits the instruction into its fields, extends the immediate, classifies
// the instruction and carries its PC, with valid/ready on both sides.
// Optional feature macro: ID_LOAD_USE_STALL_EN enables the load-use stall;
// without it no stall is ever inserted and hazard_stall is tied low.

module instr_decode_stage #(
  parameter int IMM_EXT_W = 32,
  parameter int PC_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_W-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_op,
  output logic [5:0]           out_func,
  output logic [4:0]           out_rs,
  output logic [4:0]           out_rt,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_sa,
  output logic [IMM_EXT_W-1:0] out_imm_ext,
  output logic [25:0]          out_addr,
  output logic [PC_W-1:0]      out_pc,
  output logic [1:0]           out_type,
  output logic                 out_is_load,
  output logic                 hazard_stall
);

  // Opcodes the stage needs to recognise
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SW      = 6'h2B;

  typedef enum logic [1:0] {
    TYPE_R = 2'd0,
    TYPE_I = 2'd1,
    TYPE_J = 2'd2
  } instr_type_e;

  // Instruction class from the primary opcode
  function automatic instr_type_e decode_type(input logic [5:0] op);
    instr_type_e t;
    case (op)
      OP_SPECIAL:     t = TYPE_R;
      OP_J, OP_JAL:   t = TYPE_J;
      default:        t = TYPE_I;
    endcase
    return t;
  endfunction

  // Loads are the only producers that can cause a load-use hazard
  function automatic logic is_load_op(input logic [5:0] op);
    logic r;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

  // Instructions that read rt as a source register
  function automatic logic uses_rt_op(input logic [5:0] op);
    logic r;
    case (op)
      OP_SPECIAL, OP_SW, OP_BEQ, OP_BNE: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  // Logical immediates are zero-extended; everything else is sign-extended
  function automatic logic zero_ext_op(input logic [5:0] op);
    logic r;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

  // Extend a 16-bit immediate to IMM_EXT_W; fill-then-overwrite works for IMM_EXT_W==16 too
  function automatic logic [IMM_EXT_W-1:0] extend_imm(input logic [15:0] imm,
                                                      input logic        zero_ext);
    logic [IMM_EXT_W-1:0] r;
    logic                 fill;
    fill = zero_ext ? 1'b0 : imm[15];
    r = {IMM_EXT_W{fill}};
    r[15:0] = imm;
    return r;
  endfunction

  // Fields of the incoming instruction
  logic [5:0] in_op_s;
  logic [4:0] in_rs_s;
  logic [4:0] in_rt_s;

  assign in_op_s = in_instr[31:26];
  assign in_rs_s = in_instr[25:21];
  assign in_rt_s = in_instr[20:16];

  // Stage registers
  logic                 valid_q,   valid_d;
  logic [5:0]           op_q,      op_d;
  logic [5:0]           func_q,    func_d;
  logic [4:0]           rs_q,      rs_d;
  logic [4:0]           rt_q,      rt_d;
  logic [4:0]           rd_q,      rd_d;
  logic [4:0]           sa_q,      sa_d;
  logic [IMM_EXT_W-1:0] imm_ext_q, imm_ext_d;
  logic [25:0]          addr_q,    addr_d;
  logic [PC_W-1:0]      pc_q,      pc_d;
  logic [1:0]           type_q,    type_d;
  logic                 is_load_q, is_load_d;

  logic hazard_s;
  logic accept_s;

`ifdef ID_LOAD_USE_STALL_EN
  // Load in the stage whose destination is read by the waiting instruction
  always_comb begin
    hazard_s = 1'b0;
    if (in_valid && valid_q && is_load_q && (rt_q != 5'd0)) begin
      hazard_s = (in_rs_s == rt_q) || (uses_rt_op(in_op_s) && (in_rt_s == rt_q));
    end else begin
      hazard_s = 1'b0;
    end
  end
`else
  // Load-use stall compiled out: the stage never blocks for a hazard
  always_comb begin
    hazard_s = 1'b0;
  end
`endif

  // Accept when not flushing, not stalled, and the output slot is free or draining
  always_comb begin
    in_ready = !flush && !hazard_s && (!valid_q || out_ready);
    accept_s = in_valid && in_ready;
  end

  // Next-state: flush empties, accept loads a new decode, handshake drains to a bubble
  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    func_d    = func_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    sa_d      = sa_q;
    imm_ext_d = imm_ext_q;
    addr_d    = addr_q;
    pc_d      = pc_q;
    type_d    = type_q;
    is_load_d = is_load_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d   = 1'b1;
      op_d      = in_op_s;
      func_d    = in_instr[5:0];
      rs_d      = in_rs_s;
      rt_d      = in_rt_s;
      rd_d      = in_instr[15:11];
      sa_d      = in_instr[10:6];
      imm_ext_d = extend_imm(in_instr[15:0], zero_ext_op(in_op_s));
      addr_d    = in_instr[25:0];
      pc_d      = in_pc;
      type_d    = decode_type(in_op_s);
      is_load_d = is_load_op(in_op_s);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State register with synchronous reset clearing every field
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      op_q      <= 6'd0;
      func_q    <= 6'd0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      rd_q      <= 5'd0;
      sa_q      <= 5'd0;
      imm_ext_q <= {IMM_EXT_W{1'b0}};
      addr_q    <= 26'd0;
      pc_q      <= {PC_W{1'b0}};
      type_q    <= 2'd0;
      is_load_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      func_q    <= func_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      sa_q      <= sa_d;
      imm_ext_q <= imm_ext_d;
      addr_q    <= addr_d;
      pc_q      <= pc_d;
      type_q    <= type_d;
      is_load_q <= is_load_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_op       = op_q;
  assign out_func     = func_q;
  assign out_rs       = rs_q;
  assign out_rt       = rt_q;
  assign out_rd       = rd_q;
  assign out_sa       = sa_q;
  assign out_imm_ext  = imm_ext_q;
  assign out_addr     = addr_q;
  assign out_pc       = pc_q;
  assign out_type     = type_q;
  assign out_is_load  = is_load_q;
  assign hazard_stall = hazard_s;

endmodule
